// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: executor state encoding and queue entry sizing.
package mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } exec_state_e;

  localparam int WAIT_CNT_BITS = 4;

  // Queue entry layout, MSB first: {we, word index, write data}
  function automatic int entry_width(input int membits, input int databits);
    return 1 + membits + databits;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Cache-to-memory port: request side driven by the cache (master), response side by memory (slave).
interface mem_responder_if #(
  parameter int ADDRBITS = 32,
  parameter int DATABITS = 32
);
  logic [ADDRBITS-1:0] mem_addr;
  logic [DATABITS-1:0] mem_in;
  logic                mem_rdreq;
  logic                mem_wrreq;
  logic [DATABITS-1:0] mem_out;
  logic                mem_out_valid;
  logic                busy;
  logic                ovf_err;
  logic                proto_err;

  modport master (
    output mem_addr, mem_in, mem_rdreq, mem_wrreq,
    input  mem_out, mem_out_valid, busy, ovf_err, proto_err
  );

  modport slave (
    input  mem_addr, mem_in, mem_rdreq, mem_wrreq,
    output mem_out, mem_out_valid, busy, ovf_err, proto_err
  );
endinterface

// File: rtl/mem_responder_fifo.sv
// Request queue: synchronous FIFO that accepts a push while full if the head is popped in the same cycle.
module mem_req_fifo #(
  parameter int WIDTH = 8,
  parameter int QBITS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int DEPTH = 2 ** QBITS;

  logic [WIDTH-1:0] slot_q [DEPTH];
  logic [QBITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [QBITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [QBITS:0]   count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == (QBITS+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = slot_q[rd_ptr_q];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + QBITS'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + QBITS'(1) : rd_ptr_q;
    count_d  = count_q + (QBITS+1)'(do_push) - (QBITS+1)'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slot_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: queues read/write requests in order and serves them from an on-chip word RAM.
// state | meaning:  IDLE | pop head, writes retire here ;  WAIT | read wait states ;  RESP | mem_out_valid pulse
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDRBITS     = 32,
  parameter int DATABITS     = 32,
  parameter int MEMADDRBITS  = 10,
  parameter int QBITS        = 2,
  parameter int READ_LATENCY = 2
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus
);
  localparam int EW    = entry_width(MEMADDRBITS, DATABITS);
  localparam int WORDS = 2 ** MEMADDRBITS;
  localparam logic [WAIT_CNT_BITS-1:0] LAT_M1 = WAIT_CNT_BITS'(READ_LATENCY - 1);

  logic [DATABITS-1:0] ram [0:WORDS-1];
  logic [DATABITS-1:0] ram_rdata_q;

  exec_state_e              state_q, state_d;
  logic [WAIT_CNT_BITS-1:0] wait_cnt_q, wait_cnt_d;
  logic [DATABITS-1:0]      mem_out_q, mem_out_d;
  logic                     ovf_q, ovf_d;
  logic                     proto_q, proto_d;

  logic                   req, fifo_pop, fifo_full, fifo_empty;
  logic                   ram_we, ram_re;
  logic [EW-1:0]          push_entry, head;
  logic                   head_we;
  logic [MEMADDRBITS-1:0] head_idx;
  logic [DATABITS-1:0]    head_data;
  logic                   unused_addr;

  // Address bits outside the word index alias onto the same RAM word.
  assign unused_addr = ^{bus.mem_addr[ADDRBITS-1:MEMADDRBITS+2], bus.mem_addr[1:0]};

  assign req        = bus.mem_rdreq | bus.mem_wrreq;
  assign push_entry = {bus.mem_wrreq, bus.mem_addr[MEMADDRBITS+1:2], bus.mem_in};
  assign head_we    = head[EW-1];
  assign head_idx   = head[EW-2 -: MEMADDRBITS];
  assign head_data  = head[DATABITS-1:0];

  mem_req_fifo #(
    .WIDTH (EW),
    .QBITS (QBITS)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req),
    .pop   (fifo_pop),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    mem_out_d  = mem_out_q;
    fifo_pop   = 1'b0;
    ram_we     = 1'b0;
    ram_re     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (head_we) begin
            ram_we = 1'b1;
          end else begin
            ram_re     = 1'b1;
            wait_cnt_d = LAT_M1;
            state_d    = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == '0) begin
          mem_out_d = ram_rdata_q;
          state_d   = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_CNT_BITS'(1);
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A dropped request is one arriving on a full queue that is not being drained this cycle.
  always_comb begin
    ovf_d   = ovf_q | (req & fifo_full & ~fifo_pop);
    proto_d = proto_q | (bus.mem_rdreq & bus.mem_wrreq);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      mem_out_q  <= '0;
      ovf_q      <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      mem_out_q  <= mem_out_d;
      ovf_q      <= ovf_d;
      proto_q    <= proto_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[head_idx] <= head_data;
    if (ram_re) ram_rdata_q <= ram[head_idx];
  end

  assign bus.mem_out       = mem_out_q;
  assign bus.mem_out_valid = (state_q == ST_RESP);
  assign bus.busy          = !fifo_empty || (state_q != ST_IDLE);
  assign bus.ovf_err       = ovf_q;
  assign bus.proto_err     = proto_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed and random stimulus for mem_responder checked each cycle against a transaction-level model.
module tb_mem_responder;
  localparam int LAT   = 2;
  localparam int MAB   = 10;
  localparam int QB    = 2;
  localparam int DEPTH = 2 ** QB;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.ADDRBITS(32), .DATABITS(32)) bus ();

  mem_responder #(
    .ADDRBITS(32), .DATABITS(32), .MEMADDRBITS(MAB), .QBITS(QB), .READ_LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { logic we; int unsigned idx; logic [31:0] data; } req_t;
  typedef struct { int unsigned cyc; logic [31:0] data; } resp_t;

  req_t        q_m[$];
  resp_t       resp_m[$];
  logic [31:0] mem_m [int unsigned];
  int unsigned cyc = 0;
  int unsigned free_at = 0;
  logic [31:0] last_out = '0;
  logic        ovf_m = 1'b0;
  logic        proto_m = 1'b0;
  int          checks = 0;
  int          failures = 0;

  function automatic int unsigned word_idx(input logic [31:0] a);
    return (a / 4) % (1 << MAB);
  endfunction

  task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // Called at a falling edge: check this cycle's outputs, drive inputs, advance the model one cycle.
  task automatic step(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] data);
    logic        exp_valid;
    logic [31:0] exp_out;
    req_t        h;
    exp_valid = 1'b0;
    exp_out   = last_out;
    if (resp_m.size() > 0 && resp_m[0].cyc == cyc) begin
      exp_valid = 1'b1;
      exp_out   = resp_m[0].data;
      last_out  = exp_out;
      void'(resp_m.pop_front());
    end
    check1("valid", 32'(bus.mem_out_valid), 32'(exp_valid));
    check1("mem_out", bus.mem_out, exp_out);
    check1("busy", 32'(bus.busy), 32'(q_m.size() != 0 || cyc < free_at));
    check1("ovf_err", 32'(bus.ovf_err), 32'(ovf_m));
    check1("proto_err", 32'(bus.proto_err), 32'(proto_m));

    bus.mem_rdreq = rd;
    bus.mem_wrreq = wr;
    bus.mem_addr  = addr;
    bus.mem_in    = data;

    if (cyc >= free_at && q_m.size() > 0) begin
      h = q_m.pop_front();
      if (h.we) begin
        mem_m[h.idx] = h.data;
      end else begin
        resp_m.push_back('{cyc: cyc + LAT + 1, data: mem_m.exists(h.idx) ? mem_m[h.idx] : 32'h0});
        free_at = cyc + LAT + 2;
      end
    end
    if (rd && wr) proto_m = 1'b1;
    if (rd || wr) begin
      if (q_m.size() < DEPTH) q_m.push_back('{we: wr, idx: word_idx(addr), data: data});
      else ovf_m = 1'b1;
    end

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_rdreq = 1'b0;
    bus.mem_wrreq = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_in    = '0;
    #1;
    check1("rst_valid", 32'(bus.mem_out_valid), 32'h0);
    check1("rst_mem_out", bus.mem_out, 32'h0);
    check1("rst_busy", 32'(bus.busy), 32'h0);
    check1("rst_ovf", 32'(bus.ovf_err), 32'h0);
    check1("rst_proto", 32'(bus.proto_err), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    q_m.delete();
    resp_m.delete();
    free_at  = 0;
    last_out = '0;
    ovf_m    = 1'b0;
    proto_m  = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;

    do_reset();
    idle(2);

    // Preload the low 16 words so every later read has a defined expectation.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 32'(i * 4), $urandom());
    idle(3);

    // Write then immediately read the same word.
    step(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
    step(1'b1, 1'b0, 32'h10, 32'h0);
    idle(6);
    check1("t1_data", bus.mem_out, 32'hDEADBEEF);

    // Reset while a read sits in its wait states.
    step(1'b1, 1'b0, 32'h8, 32'h0);
    idle(2);
    do_reset();
    idle(8);

    // Seven back-to-back reads: four queued plus one in flight, the seventh is dropped.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 32'(i * 4), 32'h0);
    idle(32);
    check1("t3_ovf", 32'(bus.ovf_err), 32'h1);

    do_reset();
    // Simultaneous read and write: write wins, read dropped.
    step(1'b1, 1'b1, 32'h20, 32'h55);
    idle(6);
    step(1'b1, 1'b0, 32'h20, 32'h0);
    idle(6);
    check1("t4_proto", 32'(bus.proto_err), 32'h1);
    check1("t4_data", bus.mem_out, 32'h55);

    // Four writes then four reads in order.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i));
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'(i * 4), 32'h0);
    idle(24);

    // Aliased address reaches word 4.
    step(1'b0, 1'b1, 32'h0000_1010, 32'h1234_5678);
    step(1'b1, 1'b0, 32'h0000_0010, 32'h0);
    idle(6);
    check1("alias_data", bus.mem_out, 32'h1234_5678);

    // Random traffic over a small aliased address window.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      a = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      if (r < 30)      step(1'b1, 1'b0, a, $urandom());
      else if (r < 58) step(1'b0, 1'b1, a, $urandom());
      else if (r < 60) step(1'b1, 1'b1, a, $urandom());
      else             step(1'b0, 1'b0, a, $urandom());
    end
    idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
